// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
// Produces {remainder, quotient}; holds the pipeline through div_stall while iterating.
module div_iter_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               valid,
   input  logic               sign,
   output logic               div_stall,
   output logic [2*WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] counter;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] dividend_raw;
   logic             quo_neg;
   logic             rem_neg;
   logic             b_zero;

   logic             start;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             borrow;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] quo_fix;

   assign start = (state == IDLE) && valid && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      div_stall  = 1'b0;
      case (state)
         IDLE: begin
            if (valid && !flush) begin
               state_next = BUSY;
               div_stall  = 1'b1;
            end
         end
         BUSY: begin
            div_stall = 1'b1;
            if (flush) begin
               state_next = IDLE;
            end else if (counter == LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (flush || valid) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One restoring step: the partial remainder needs one extra bit so the borrow is visible.
   always_comb begin
      shifted  = {rem_q, quo_q[WIDTH-1]};
      trial    = shifted - {1'b0, divisor_q};
      borrow   = trial[WIDTH];
      rem_next = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], ~borrow};
      quo_fix  = quo_neg ? (~quo_next + 1'b1) : quo_next;
      rem_fix  = rem_neg ? (~rem_next + 1'b1) : rem_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter      <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         divisor_q    <= '0;
         dividend_raw <= '0;
         quo_neg      <= 1'b0;
         rem_neg      <= 1'b0;
         b_zero       <= 1'b0;
         result       <= '0;
      end else if (start) begin
         counter      <= '0;
         rem_q        <= '0;
         quo_q        <= (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
         divisor_q    <= (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;
         dividend_raw <= a;
         quo_neg      <= (a[WIDTH-1] ^ b[WIDTH-1]) && sign;
         rem_neg      <= a[WIDTH-1] && sign;
         b_zero       <= (b == '0);
      end else if ((state == BUSY) && !flush) begin
         rem_q   <= rem_next;
         quo_q   <= quo_next;
         counter <= counter + 1'b1;
         // Divide by zero bypasses the sign fixup and returns the raw dividend.
         if (counter == LAST) begin
            result <= b_zero ? {dividend_raw, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
         end
      end
   end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit (WIDTH=32).
// Covers latency, signed/unsigned results, overflow, divide by zero, flush, reset and DONE hold.
module tb_div_iter_unit;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [31:0] a;
   logic [31:0] b;
   logic        valid;
   logic        sign;
   logic        div_stall;
   logic [63:0] result;

   int checks   = 0;
   int failures = 0;

   div_iter_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .a         (a),
      .b         (b),
      .valid     (valid),
      .sign      (sign),
      .div_stall (div_stall),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one op in IDLE, scrambles operands while busy, and leaves the unit parked in DONE.
   task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                                input logic [63:0] exp, input string tag);
      int n;
      tick();
      a = ta; b = tb_v; sign = ts; valid = 1'b1;
      #1;
      n = 0;
      while (div_stall && n < 60) begin
         n++;
         tick();
         valid = 1'b0;
         a = ~ta;
         b = ta ^ 32'h5a5a_0f0f;
         sign = ~ts;
         #1;
      end
      checkOutput({tag, "_lat"}, 64'(n), 64'd33);
      checkOutput({tag, "_res"}, result, exp);
   endtask

   task automatic consume(input logic [63:0] exp, input string tag);
      tick();
      valid = 1'b1;
      #1;
      checkOutput({tag, "_cons_stall"}, {63'd0, div_stall}, 64'd0);
      checkOutput({tag, "_cons_res"}, result, exp);
   endtask

   initial begin
      logic [63:0] held;
      rst = 1'b1; flush = 1'b0; a = '0; b = '0; valid = 1'b0; sign = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset_stall", {63'd0, div_stall}, 64'd0);
      checkOutput("reset_result", result, 64'd0);
      rst = 1'b0;

      applyStimulus(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, "divu_100_7");
      consume({32'd2, 32'd14}, "divu_100_7");
      applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
      consume({32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
      applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, "div_7_m2");
      consume({32'd1, 32'hFFFF_FFFD}, "div_7_m2");
      applyStimulus(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'd14}, "div_m100_m7");
      consume({32'hFFFF_FFFE, 32'd14}, "div_m100_m7");
      applyStimulus(32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, "divu_big");
      consume({32'hF, 32'h0FFF_FFFF}, "divu_big");
      applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, "div_ovf");
      consume({32'd0, 32'h8000_0000}, "div_ovf");
      applyStimulus(32'h1234, 32'd0, 1'b0, {32'h1234, 32'hFFFF_FFFF}, "divu_by0");
      consume({32'h1234, 32'hFFFF_FFFF}, "divu_by0");
      applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, "div_by0");
      consume({32'hFFFF_FFF9, 32'hFFFF_FFFF}, "div_by0");

      // Flush ten cycles into an op: stall drops one cycle later and result is untouched.
      held = {32'hFFFF_FFF9, 32'hFFFF_FFFF};
      tick();
      a = 32'd1000; b = 32'd3; sign = 1'b0; valid = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         valid = 1'b0;
      end
      tick();
      flush = 1'b1;
      #1;
      checkOutput("flush_busy_stall", {63'd0, div_stall}, 64'd1);
      tick();
      flush = 1'b0;
      #1;
      checkOutput("flush_after_stall", {63'd0, div_stall}, 64'd0);
      checkOutput("flush_after_res", result, held);
      applyStimulus(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, "divu_9_3");
      consume({32'd0, 32'd3}, "divu_9_3");

      // Flush in IDLE suppresses the start entirely.
      tick();
      a = 32'd20; b = 32'd4; valid = 1'b1; flush = 1'b1;
      #1;
      checkOutput("flush_idle_stall", {63'd0, div_stall}, 64'd0);
      tick();
      valid = 1'b0; flush = 1'b0;
      #1;
      checkOutput("flush_idle_next", {63'd0, div_stall}, 64'd0);
      checkOutput("flush_idle_res", result, {32'd0, 32'd3});

      // Asynchronous reset between edges in the middle of BUSY.
      tick();
      a = 32'd50; b = 32'd5; sign = 1'b0; valid = 1'b1;
      repeat (5) begin
         tick();
         valid = 1'b0;
      end
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_stall", {63'd0, div_stall}, 64'd0);
      checkOutput("rst_mid_res", result, 64'd0);
      #1;
      rst = 1'b0;
      applyStimulus(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, "divu_50_5");

      // External stall: DONE holds with valid low.
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         checkOutput("done_hold_stall", {63'd0, div_stall}, 64'd0);
         checkOutput("done_hold_res", result, {32'd0, 32'd10});
      end
      consume({32'd0, 32'd10}, "divu_50_5");
      applyStimulus(32'd81, 32'd9, 1'b0, {32'd0, 32'd9}, "divu_81_9");
      consume({32'd0, 32'd9}, "divu_81_9");
      tick();
      valid = 1'b0;
      #1;
      checkOutput("final_idle_stall", {63'd0, div_stall}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
